// File: rtl/yout_pkg.sv
// Shared types and defaults for the Yout bit-stream packer.
// Imported by the interface, the output FIFO and the packer top.
package yout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } state_e;

    localparam int YOUT_WORD_W     = 8;
    localparam int YOUT_FIFO_DEPTH = 2;

    // Width of a field that counts 0..w inclusive.
    function automatic int len_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/yout_packer_if.sv
// Word output channel of the packer: FIFO head plus valid/ready handshake.
// Master drives the head entry; slave returns ready.
interface yout_packer_if #(
    parameter int WORD_W = yout_pkg::YOUT_WORD_W
);
    import yout_pkg::*;

    localparam int LW = len_w(WORD_W);

    logic [WORD_W-1:0] word_out;
    logic [LW-1:0]     word_len;
    logic [LW-1:0]     word_ones;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_out,
        output word_len,
        output word_ones,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_len,
        input  word_ones,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/yout_word_fifo.sv
// Small synchronous FIFO of {data, len, ones} entries.
// Pointers carry one extra wrap bit; head is zeroed while empty.
module yout_word_fifo
    import yout_pkg::*;
#(
    parameter int W     = YOUT_WORD_W,
    parameter int DEPTH = YOUT_FIFO_DEPTH,
    parameter int LW    = len_w(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic [LW-1:0] len_i,
    input  logic [LW-1:0] ones_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic [LW-1:0] len_o,
    output logic [LW-1:0] ones_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  data_q [DEPTH];
    logic [LW-1:0] len_q  [DEPTH];
    logic [LW-1:0] ones_q [DEPTH];

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (push_i) wp_d = wp_q + PW'(1);
        if (pop_i)  rp_d = rp_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            data_q[wp_q[AW-1:0]] <= data_i;
            len_q[wp_q[AW-1:0]]  <= len_i;
            ones_q[wp_q[AW-1:0]] <= ones_i;
        end
    end

    assign empty_o = (wp_q == rp_q);
    assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                     (wp_q[AW-1:0] == rp_q[AW-1:0]);

    // Gating keeps the head at zero after reset and when drained.
    assign data_o = empty_o ? '0 : data_q[rp_q[AW-1:0]];
    assign len_o  = empty_o ? '0 : len_q[rp_q[AW-1:0]];
    assign ones_o = empty_o ? '0 : ones_q[rp_q[AW-1:0]];

endmodule

// File: rtl/yout_packer.sv
// Packs the serial Yout stream LSB-first into words with popcount,
// holding a finished word when the output FIFO has no room.
module yout_packer
    import yout_pkg::*;
#(
    parameter int WORD_W     = YOUT_WORD_W,
    parameter int FIFO_DEPTH = YOUT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             flush,
    yout_packer_if.master    wif,
    output logic             overflow,
    output logic             busy
);

    localparam int LW = len_w(WORD_W);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     ones_q, ones_d;
    logic              ovf_q, ovf_d;

    logic [WORD_W-1:0] acc_n;
    logic [LW-1:0]     cnt_n;
    logic [LW-1:0]     ones_n;

    logic [WORD_W-1:0] w_acc;
    logic [LW-1:0]     w_cnt;
    logic [LW-1:0]     w_ones;

    logic push, pop, full, empty, space;
    logic take_bit, want_push;

    assign pop   = wif.word_valid && wif.word_ready;
    assign space = !full || pop;

    always_comb begin
        acc_n  = acc_q | (WORD_W'(bit_in) << cnt_q);
        cnt_n  = cnt_q + LW'(1);
        ones_n = ones_q + LW'(bit_in);

        take_bit  = (state_q != HOLD) && bit_valid;
        want_push = 1'b0;

        w_acc  = acc_q;
        w_cnt  = cnt_q;
        w_ones = ones_q;

        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        ovf_d   = ovf_q;
        push    = 1'b0;

        if (take_bit) begin
            w_acc  = acc_n;
            w_cnt  = cnt_n;
            w_ones = ones_n;
        end

        unique case (1'b1)
            state_q == HOLD: begin
                want_push = 1'b1;
                if (bit_valid) ovf_d = 1'b1;
            end
            default: begin
                // A bit arriving with flush joins the word before it leaves.
                want_push = (take_bit && cnt_n == LW'(WORD_W)) ||
                            (flush && state_q == FILL);
            end
        endcase

        if (want_push && space) begin
            push    = 1'b1;
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ones_d  = '0;
        end else if (want_push) begin
            state_d = HOLD;
            acc_d   = w_acc;
            cnt_d   = w_cnt;
            ones_d  = w_ones;
        end else if (take_bit) begin
            state_d = FILL;
            acc_d   = acc_n;
            cnt_d   = cnt_n;
            ones_d  = ones_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ones_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            ovf_q   <= ovf_d;
        end
    end

    yout_word_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (w_acc),
        .len_i   (w_cnt),
        .ones_i  (w_ones),
        .pop_i   (pop),
        .data_o  (wif.word_out),
        .len_o   (wif.word_len),
        .ones_o  (wif.word_ones),
        .full_o  (full),
        .empty_o (empty)
    );

    assign wif.word_valid = !empty;
    assign overflow       = ovf_q;
    assign busy           = (state_q != IDLE) || !empty;

endmodule

// File: doc/yout_packer.md
# yout_packer

Serial-to-parallel packing stage placed directly downstream of the bit-level decision core. It captures the core's 1-bit `Yout` stream on qualified cycles, assembles `WORD_W`-bit words LSB-first and counts the ones in each word. Completed words go through a small output FIFO with a valid/ready handshake toward the result collector. Flush and overflow handling let the bench and the system controller drain partial words and detect lost bits.

## Interface
- `WORD_W`, default 8, word width in bits (≥2).
- `FIFO_DEPTH`, default 2, output FIFO entries (power of two, ≥2).

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `reset`, input, 1, synchronous, active-high; clears all state.
- `bit_in`, input, 1, data bit from the upstream `Yout`.
- `bit_valid`, input, 1, `bit_in` is sampled this cycle.
- `flush`, input, 1, single-cycle request to emit the partial word.
- `word_out`, output, `WORD_W`, FIFO head data.
- `word_len`, output, `$clog2(WORD_W+1)`, number of valid bits in `word_out`.
- `word_ones`, output, `$clog2(WORD_W+1)`, popcount of `word_out`.
- `word_valid`, output, 1, FIFO head is valid.
- `word_ready`, input, 1, consumer accepts the head this cycle.
- `overflow`, output, 1, sticky: at least one bit has been dropped.
- `busy`, output, 1, FSM not in IDLE, or FIFO not empty.

## Operation
- **Assembly register `acc`** (`WORD_W` bits) and **bit counter `cnt`**.
  - An accepted bit is written to `acc[cnt]`; the first bit lands in bit 0.
  - `ones` tracks the running popcount.
- **FSM states:** IDLE (`cnt`=0), FILL (0<`cnt`<`WORD_W`), HOLD (completed word waiting for FIFO space).
- **IDLE/FILL behaviour:**
  - `bit_valid` accepts the bit.
  - When the accepted bit makes `cnt`=`WORD_W`, the word is pushed with len=`WORD_W`, provided the FIFO has space. Space exists if the FIFO is not full, or if a pop happens in the same cycle.
  - After a push: `cnt`, `ones` and `acc` clear, and the FSM goes to IDLE.
  - If there is no space, the FSM goes to HOLD and keeps the word.
- **HOLD behaviour:**
  - Push the held word on the first cycle with space, then go to IDLE.
  - Any `bit_valid` while in HOLD, including the cycle the push happens, drops the bit and sets `overflow`.
- **Flush:**
  - In FILL, `flush` pushes the partial word zero-padded in the upper bits, with len=`cnt`. The same push/HOLD rules apply.
  - In IDLE, `flush` is ignored.
  - In HOLD, `flush` is ignored; the held word is already complete.
  - If `flush` and `bit_valid` are both high in FILL, the bit is included first, then the word is pushed with len=`cnt`+1. If that bit completes the word, len=`WORD_W` and it is a single push, not two.
- **FIFO:**
  - Circular buffer with read/write pointers one bit wider than the index.
  - `word_valid` = not empty.
  - A pop occurs when `word_valid && word_ready`.
  - `word_out`, `word_len` and `word_ones` come straight from the head entry. Popcount is stored per entry, not recomputed at the output.
- **Reset in mid-operation** discards the partial word, the held word and all FIFO contents, and clears `overflow`.

## Timing
- **Reset values:** `word_out`=0, `word_len`=0, `word_ones`=0, `word_valid`=0, `overflow`=0, `busy`=0.
- **Latency:**
  - Word-completing bit accepted at edge N → `word_valid`=1 after edge N when the FIFO was empty, i.e. visible in cycle N+1.
  - HOLD → push occurs on the edge where space exists; the word is visible in the following cycle.
- **Handshake:**
  - Head data is stable while `word_valid && !word_ready`.
  - `word_valid` never depends combinationally on `word_ready`.
  - `word_ready` with an empty FIFO has no effect.
- **Full FIFO with a simultaneous pop and push** is legal: the count is unchanged and no drop occurs.
- **Throughput:** one bit per cycle is sustained indefinitely as long as `word_ready` is high at least one cycle per `WORD_W`.
- **`overflow`** rises on the edge after the first dropped bit and stays high until `reset`.

## Structure
- Shared package `yout_pkg`:
  - FSM state enum `{IDLE, FILL, HOLD}`.
  - Defaults `YOUT_WORD_W`=8 and `YOUT_FIFO_DEPTH`=2.
  - Width function for `len`/`ones`.
- One sub-module, `yout_word_fifo`:
  - Parameterised sync FIFO carrying {data, len, ones}.
  - Provides push, pop, full, empty.
- The top holds the assembler and the FSM.

## Test plan
- **Basic packing:** reset held 2 cycles, then 8 consecutive bits 1,0,1,1,0,0,0,1 with `word_ready`=1.
  - Expect `word_out`=8'h8D, `word_len`=8, `word_ones`=4, `word_valid` high for exactly 1 cycle, the cycle after the 8th bit.
- **Partial flush:** 3 bits 1,1,0, then `flush`.
  - Expect `word_out`=8'h03, `word_len`=3, `word_ones`=2.
  - A `flush` in IDLE afterwards produces no word.
- **Backpressure and HOLD:** `word_ready`=0, feed 24 bits of 1s, then 8 more with `bit_valid`.
  - Expect 2 words queued, FSM in HOLD, the next 8 bits dropped, `overflow`=1.
  - After raising `word_ready`: 3 words of 8'hFF in order, then `busy`=0.
- **Simultaneous flush and bit:** 7 bits then bit 8 with `flush` in the same cycle.
  - Expect exactly one word with `word_len`=8.
- **Full FIFO pop+push:** FIFO full, `word_ready`=1 on the cycle the 8th bit of the next word arrives.
  - Expect no HOLD and no `overflow`; word order preserved.
- **Reset mid-operation:** reset asserted with 5 partial bits, 2 queued words and `overflow`=1.
  - Expect all outputs at reset values on the next cycle.
  - A following 8-bit word packs from bit 0.
